// File: rtl/ccr_unit.sv
// rtl/ccr_unit.sv - condition-code register with branch evaluation and interrupt shadow stack (option: CCR_FORWARD_EN)
module ccr_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       alu_op,
  input  logic             alu_valid,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             jmp_valid,
  input  logic [1:0]       jmp_cond,
  input  logic             int_save,
  input  logic             rti_restore,
  output logic [2:0]       ccr,
  output logic             take_branch,
  output logic [PTR_W-1:0] stack_depth,
  output logic             ovf,
  output logic             unf
);

  // Storage is rounded up to a power of two so the depth count slices cleanly into an index.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

  logic [2:0]       stack_q [SLOTS];
  logic [2:0]       upd;
  logic [2:0]       src;
  logic [2:0]       nf;
  logic [PTR_W-1:0] dm1;

  // ALU flag update applied to the current flags; ccr bit order is {C,N,Z}.
  always_comb begin
    upd = ccr;
    if (alu_valid) begin
      case (alu_op)
        4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8: upd = {alu_carry, alu_neg, alu_zero};
        4'd9, 4'd10:                              upd = {ccr[2], alu_neg, alu_zero};
        4'd11:                                    upd[2] = 1'b1;
        4'd12:                                    upd[2] = 1'b0;
        default:                                  upd = ccr;
      endcase
    end
  end

  // Branch condition evaluation and the consumed-flag clear that produces nf.
  always_comb begin
`ifdef CCR_FORWARD_EN
    src = upd;
`else
    src = ccr;
`endif
    take_branch = 1'b0;
    nf = upd;
    if (en && jmp_valid) begin
      case (jmp_cond)
        2'b01:   take_branch = src[0];
        2'b10:   take_branch = src[1];
        2'b11:   take_branch = src[2];
        default: take_branch = 1'b0;
      endcase
    end
    if (take_branch) begin
      case (jmp_cond)
        2'b01:   nf[0] = 1'b0;
        2'b10:   nf[1] = 1'b0;
        default: nf[2] = 1'b0;
      endcase
    end
  end

  assign dm1 = stack_depth - ONE;

  // Flag register, shadow stack and sticky error flags; restore beats every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr         <= 3'b000;
      stack_depth <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        stack_q[i] <= 3'b000;
      end
    end else if (en) begin
      if (rti_restore) begin
        if (stack_depth != '0) begin
          ccr         <= stack_q[dm1[IDX_W-1:0]];
          stack_depth <= dm1;
        end else begin
          ccr <= nf;
          unf <= 1'b1;
        end
      end else if (int_save) begin
        ccr <= nf;
        if (stack_depth != FULL) begin
          stack_q[stack_depth[IDX_W-1:0]] <= nf;
          stack_depth <= stack_depth + ONE;
        end else begin
          ovf <= 1'b1;
        end
      end else begin
        ccr <= nf;
      end
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// tb/tb_ccr_unit.sv - directed self-checking bench for ccr_unit (honours CCR_FORWARD_EN)
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] alu_op;
  logic       alu_valid;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_neg;
  logic       jmp_valid;
  logic [1:0] jmp_cond;
  logic       int_save;
  logic       rti_restore;
  logic [2:0] ccr;
  logic       take_branch;
  logic [2:0] stack_depth;
  logic       ovf;
  logic       unf;

  int total = 0;
  int bad   = 0;

  logic [2:0] push_vals [5];

  ccr_unit #(.DEPTH(4), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .alu_op(alu_op), .alu_valid(alu_valid),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .jmp_valid(jmp_valid), .jmp_cond(jmp_cond), .int_save(int_save),
    .rti_restore(rti_restore), .ccr(ccr), .take_branch(take_branch),
    .stack_depth(stack_depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; alu_op = 4'd0; alu_valid = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0;
    alu_neg = 1'b0; jmp_valid = 1'b0; jmp_cond = 2'b00; int_save = 1'b0; rti_restore = 1'b0;
  endtask

  task automatic alu(input logic [3:0] op, input logic c, input logic n, input logic z);
    alu_valid = 1'b1; alu_op = op; alu_carry = c; alu_neg = n; alu_zero = z;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    push_vals[0] = 3'b001; push_vals[1] = 3'b010; push_vals[2] = 3'b100;
    push_vals[3] = 3'b111; push_vals[4] = 3'b101;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_ccr", ccr, 3'b000);
    check("rst_depth", stack_depth, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);

    alu(4'd6, 1'b1, 1'b0, 1'b1);
    step();
    check("sub_ccr", ccr, 3'b101);
    check("sub_depth", stack_depth, 0);

    alu(4'd11, 1'b0, 1'b0, 1'b0);
    step();
    check("op11_setc", ccr, 3'b101);
    alu(4'd9, 1'b0, 1'b1, 1'b1);
    step();
    check("op9_keepc", ccr, 3'b111);
    alu(4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("op0_nochange", ccr, 3'b111);
    alu(4'd6, 1'b0, 1'b0, 1'b0);
    alu_valid = 1'b0;
    step();
    check("invalid_nochange", ccr, 3'b111);

    // JC taken with a same-cycle ALU write: C cleared, N/Z take the ALU values.
    alu(4'd6, 1'b1, 1'b1, 1'b0);
    jmp_valid = 1'b1; jmp_cond = 2'b11;
    #1;
    check("jc_take", take_branch, 1);
    step();
    check("jc_clear_ccr", ccr, 3'b010);

    alu(4'd6, 1'b0, 1'b0, 1'b1);
    step();
    check("set001", ccr, 3'b001);
    jmp_valid = 1'b1; jmp_cond = 2'b01;
    #1;
    check("jz_take", take_branch, 1);
    step();
    check("jz_clear", ccr, 3'b000);
    alu(4'd6, 1'b0, 1'b0, 1'b1);
    step();
    jmp_valid = 1'b1; jmp_cond = 2'b10;
    #1;
    check("jn_nottaken", take_branch, 0);
    step();
    check("jn_ccr_hold", ccr, 3'b001);

    alu(4'd1, 1'b1, 1'b1, 1'b0);
    step();
    check("set110", ccr, 3'b110);
    alu(4'd12, 1'b0, 1'b0, 1'b0);
    int_save = 1'b1;
    step();
    check("push_ccr", ccr, 3'b010);
    check("push_depth", stack_depth, 1);
    alu(4'd5, 1'b0, 1'b1, 1'b1);
    step();
    check("op5_ccr", ccr, 3'b011);
    alu(4'd1, 1'b1, 1'b1, 1'b1);
    rti_restore = 1'b1;
    step();
    check("pop_ccr", ccr, 3'b010);
    check("pop_depth", stack_depth, 0);

    for (int i = 0; i < 5; i++) begin
      alu(4'd1, push_vals[i][2], push_vals[i][1], push_vals[i][0]);
      int_save = 1'b1;
      step();
      check($sformatf("push%0d_depth", i), stack_depth, (i < 4) ? i + 1 : 4);
      check($sformatf("push%0d_ccr", i), ccr, push_vals[i]);
    end
    check("full_ovf", ovf, 1);
    check("full_unf", unf, 0);

    for (int i = 0; i < 5; i++) begin
      rti_restore = 1'b1;
      int_save = (i == 0);
      step();
      check($sformatf("pop%0d_ccr", i), ccr, (i < 4) ? push_vals[3 - i] : push_vals[0]);
      check($sformatf("pop%0d_depth", i), stack_depth, (i < 4) ? 3 - i : 0);
    end
    check("empty_unf", unf, 1);
    check("empty_ovf", ovf, 1);

    en = 1'b0;
    alu(4'd11, 1'b0, 1'b0, 1'b0);
    int_save = 1'b1; jmp_valid = 1'b1; jmp_cond = 2'b01;
    #1;
    check("stall_notake", take_branch, 0);
    @(posedge clk);
    #1;
    check("stall_ccr", ccr, 3'b001);
    check("stall_depth", stack_depth, 0);
    check("stall_ovf", ovf, 1);
    check("stall_unf", unf, 1);
    rst = 1'b1;
    step();
    en = 1'b0;
    rst = 1'b0;
    check("rst2_ccr", ccr, 3'b000);
    check("rst2_ovf", ovf, 0);
    check("rst2_unf", unf, 0);
    check("rst2_depth", stack_depth, 0);
    idle();

    alu(4'd6, 1'b0, 1'b0, 1'b1);
    jmp_valid = 1'b1; jmp_cond = 2'b01;
    #1;
`ifdef CCR_FORWARD_EN
    check("fwd_take", take_branch, 1);
    step();
    check("fwd_ccr", ccr, 3'b000);
`else
    check("nofwd_take", take_branch, 0);
    step();
    check("nofwd_ccr", ccr, 3'b001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
